// File: rtl/mul_acc_seq.sv
// Sequential unsigned multiply-accumulate engine for dot products.
// Operand beats stream in through a valid/ready handshake; a beat tagged
// last closes the stream and its result is presented on a second
// valid/ready handshake while the next stream waits.

// Unsigned multiply-add: p = x*y + a, truncated to widthA bits.
// A non-zero speed uses a single-cycle array multiply; zero selects a
// shift-and-add form that maps to a slimmer, slower adder chain.
module MulAddUns #(
  parameter int widthX = 8,
  parameter int widthY = 8,
  parameter int widthA = 20,
  parameter int speed  = 1
) (
  input  logic [widthX-1:0] x,
  input  logic [widthY-1:0] y,
  input  logic [widthA-1:0] a,
  output logic [widthA-1:0] p
);

  if (speed > 0) begin : g_fast
    assign p = widthA'(x) * widthA'(y) + a;
  end else begin : g_serial
    // Accumulate one shifted copy of y for every set bit of x
    always_comb begin
      p = a;
      for (int i = 0; i < widthX; i++) begin
        if (x[i]) begin
          p = p + (widthA'(y) << i);
        end
      end
    end
  end

endmodule

// Top level: stream controller and accumulator registers around one MulAddUns.
module mul_acc_seq #(
  parameter int widthX   = 8,
  parameter int widthY   = 8,
  parameter int widthA   = 20,
  parameter int widthCnt = 16,
  parameter int speed    = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [widthX-1:0]   x_i,
  input  logic [widthY-1:0]   y_i,
  input  logic                last_i,
  input  logic                clr_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [widthA-1:0]   acc_o,
  output logic                ovf_o,
  output logic [widthCnt-1:0] cnt_o
);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic [widthA-1:0]   acc_q;
  logic [widthCnt-1:0] cnt_q;
  logic                ovf_q;

  logic [widthA-1:0]   p;
  logic [widthCnt-1:0] cnt_inc;
  logic                wrap;
  logic                accept;
  logic                accept_last;
  logic                do_clr;

  MulAddUns #(
    .widthX(widthX),
    .widthY(widthY),
    .widthA(widthA),
    .speed (speed)
  ) u_mul_add (
    .x(x_i),
    .y(y_i),
    .a(acc_q),
    .p(p)
  );

  // The sum only ever grows, so a result smaller than the old sum means it wrapped
  assign wrap    = (p < acc_q);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + widthCnt'(1);

  // Ready is purely a function of state and flush, never of in_valid_i
  assign in_ready_o  = rst_ni & (state_q == ACCUM) & ~clr_i;
  assign out_valid_o = (state_q == HOLD);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and beat-acceptance decode; a flush takes priority over a beat
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    accept_last = 1'b0;
    do_clr      = 1'b0;
    case (state_q)
      ACCUM: begin
        if (clr_i) begin
          do_clr = 1'b1;
        end else if (in_valid_i) begin
          accept = 1'b1;
          if (last_i) begin
            accept_last = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Partial-sum registers and the presented result; the result only moves on a last beat
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      acc_o <= '0;
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (do_clr) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept_last) begin
      acc_o <= p;
      cnt_o <= cnt_inc;
      ovf_o <= ovf_q | wrap;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc_q <= p;
      cnt_q <= cnt_inc;
      ovf_q <= ovf_q | wrap;
    end
  end

endmodule

// File: doc/mul_acc_seq.md
MUL_ACC_SEQ -- requirements
Module: mul_acc_seq

Interface
REQ-001 SHALL have parameter widthX, default 8, word width of x_i (<= widthY).
REQ-002 SHALL have parameter widthY, default 8, word width of y_i.
REQ-003 SHALL have parameter widthA, default 20, accumulator/result width (>= widthX+widthY).
REQ-004 SHALL have parameter widthCnt, default 16, term counter width.
REQ-005 SHALL have parameter speed, default 1, performance parameter passed to the MulAddUns instance.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1, reset, synchronous, active-low.
REQ-008 SHALL have port in_valid_i, input, 1, operand beat valid.
REQ-009 SHALL have port in_ready_o, output, 1, operand beat accepted when in_valid_i&in_ready_o.
REQ-010 SHALL have port x_i, input, widthX, unsigned multiplier.
REQ-011 SHALL have port y_i, input, widthY, unsigned multiplicand.
REQ-012 SHALL have port last_i, input, 1, marks final beat of a dot-product stream.
REQ-013 SHALL have port clr_i, input, 1, synchronous flush of the partial sum.
REQ-014 SHALL have port out_valid_o, output, 1, result valid.
REQ-015 SHALL have port out_ready_i, input, 1, result consumed when out_valid_o&out_ready_i.
REQ-016 SHALL have port acc_o, output, widthA, dot-product result.
REQ-017 SHALL have port ovf_o, output, 1, result wrapped modulo 2^widthA at least once.
REQ-018 SHALL have port cnt_o, output, widthCnt, number of terms in result, saturating.

Function
REQ-019 SHALL compute next sum with one MulAddUns instance: P = x_i*y_i + acc_q, modulo 2^widthA.
REQ-020 SHALL implement two states: ACCUM (accepting beats) and HOLD (result presented).
REQ-021 SHALL drive in_ready_o = (state==ACCUM) & ~clr_i, combinationally, no dependence on in_valid_i.
REQ-022 SHALL, on accepted non-last beat in ACCUM: acc_q<=P, cnt_q<=cnt_q+1 (saturate at all-ones), ovf_q<=ovf_q|(P<acc_q).
REQ-023 SHALL, on accepted last beat: load acc_o<=P, cnt_o<=saturating cnt_q+1, ovf_o<=ovf_q|(P<acc_q); clear acc_q, cnt_q, ovf_q; go to HOLD.
REQ-024 SHALL assert out_valid_o exactly in HOLD; result latency one cycle after last beat acceptance.
REQ-025 SHALL hold acc_o, cnt_o, ovf_o, out_valid_o stable in HOLD until out_valid_o&out_ready_i, then go to ACCUM next cycle.
REQ-026 SHALL not accept beats in HOLD; first new beat accepted no earlier than the cycle after the output handshake.
REQ-027 SHALL, on clr_i in ACCUM: clear acc_q, cnt_q, ovf_q; no beat accepted that cycle (clr_i wins over in_valid_i).
REQ-028 SHALL ignore clr_i in HOLD; presented result unaffected.
REQ-029 SHALL treat a last beat with no prior beats as a one-term stream (result x_i*y_i, cnt_o=1).
REQ-030 SHALL keep acc_o, cnt_o, ovf_o unchanged outside REQ-023 updates.

Reset
REQ-031 SHALL, with rst_ni low at a clock edge, set state ACCUM, acc_q=0, cnt_q=0, ovf_q=0, acc_o=0, cnt_o=0, ovf_o=0, out_valid_o=0, regardless of state or in-flight stream.
REQ-032 SHALL drive in_ready_o=0 while rst_ni is low.

Verification (widthX=widthY=8, widthA=20)
REQ-033 SHALL cover: beats (3,4),(5,6),(7,8,last) back-to-back -> out_valid_o next cycle, acc_o=98, cnt_o=3, ovf_o=0.
REQ-034 SHALL cover: single beat (255,255,last) -> acc_o=65025, cnt_o=1, ovf_o=0.
REQ-035 SHALL cover: 17 beats (255,255), last on 17th -> acc_o=56849, cnt_o=17, ovf_o=1.
REQ-036 SHALL cover: out_ready_i low 5 cycles in HOLD with in_valid_i high -> acc_o stable, in_ready_o=0; in_ready_o=1 the cycle after handshake.
REQ-037 SHALL cover: beats (9,9),(10,10), clr_i with in_valid_i high, then (2,3,last) -> acc_o=6, cnt_o=1, ovf_o=0.
REQ-038 SHALL cover: rst_ni low one cycle during HOLD -> out_valid_o=0, outputs 0; next stream (1,1,last) -> acc_o=1.
